seven_segment_ctrl: RTL and testbench
=====================================

# seven_segment_ctrl

Round-robin scheduler that shares one 8-digit `seven_segment` display among `NUM_CLIENTS` requesters. It grants one client at a time and captures that client's 32-bit value. In decimal mode it converts the value to BCD with a sequential double-dabble engine. It then drives the display's `encoded`/`digit_point` inputs and holds the frame for a minimum time before accepting the next request. It sits between application logic and the `seven_segment` instance.

## Interface
- `NUM_CLIENTS`, 4: number of requesters, 2..8.
- `HOLD_CYCLES`, 100000: minimum clk cycles a frame stays displayed before re-arbitration, ≥1.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `req` in `NUM_CLIENTS`: level request; held by the client until its `ack`.
- `value` in `NUM_CLIENTS`×32: per-client value.
- `dec_mode` in `NUM_CLIENTS`: 1 = decimal, 0 = hex.
- `dp` in `NUM_CLIENTS`×8: per-client digit-point mask.
- `ack` out `NUM_CLIENTS`: one-cycle pulse to the granted client.
- `encoded` out 8×4: digit codes to `seven_segment`; digit 0 = least significant.
- `digit_point` out 8: to `seven_segment`.
- `busy` out 1: high in CONVERT or HOLD.
- `owner` out `$clog2(NUM_CLIENTS)`: index of last granted client.

## Operation
- States:
  - IDLE: no frame in progress.
  - CONVERT: double-dabble shift of 32 bits, one bit per cycle.
  - HOLD: frame displayed for `HOLD_CYCLES`.
- Arbitration:
  - Round-robin, evaluated only in IDLE.
  - Search starts at `owner+1` and wraps modulo `NUM_CLIENTS`.
  - After reset, search starts at client 0.
- Capture, on the grant edge:
  - Latch `value`, `dec_mode`, `dp` of the granted client.
  - Update `owner`.
  - Pulse `ack[owner]`.
- Hex mode:
  - `encoded[i] = value[4i+3:4i]`.
  - `digit_point = dp`.
  - Go to HOLD.
- Decimal mode with value ≤ 99_999_999:
  - Go to CONVERT.
  - After 32 iterations, load 8 BCD digits into `encoded` and `dp` into `digit_point`, then go to HOLD.
  - `encoded`/`digit_point` keep the previous frame throughout CONVERT.
- Decimal mode with value > 99_999_999 (overflow):
  - All `encoded` = 4'hE, `digit_point` = 0.
  - Skip CONVERT and go directly to HOLD.
- HOLD:
  - Counter runs 0..`HOLD_CYCLES`-1, then returns to IDLE.
  - Display retains the frame indefinitely after HOLD.
- Requests arriving while busy wait; no queuing beyond the level `req`.
- A client deasserting `req` before `ack` withdraws the request; no grant is issued to it.

## Timing
- Reset values:
  - State IDLE; `ack` = 0; `encoded` = 0; `digit_point` = 0; `busy` = 0; `owner` = `NUM_CLIENTS`-1 (so the first search starts at 0).
  - Hold counter and BCD engine are cleared.
- Reset mid-CONVERT or mid-HOLD: abandon the frame, apply all reset values next cycle, issue no `ack`.
- Let T be the IDLE cycle in which `req` is seen.
- Hex and overflow frames:
  - `ack` high in cycle T+1; new `encoded` visible in T+1.
  - `busy` high in T+1 .. T+`HOLD_CYCLES`.
  - IDLE again in T+`HOLD_CYCLES`+1.
- Decimal frames:
  - `ack` high in T+1.
  - CONVERT spans T+1..T+32; `encoded` updates visible in T+33.
  - HOLD spans T+33..T+32+`HOLD_CYCLES`.
- Back-to-back: the earliest next grant is the first IDLE cycle; there are no dead cycles beyond IDLE itself.
- Simultaneous requests: exactly one `ack` bit per grant; `ack` is never high in two consecutive cycles.

## Structure
- `seven_segment_pkg` holds:
  - `ctrl_state_t` enum {IDLE, CONVERT, HOLD}.
  - `NUM_DIGITS` = 8.
  - `DEC_MAX` = 32'd99_999_999.
  - `OVF_CODE` = 4'hE.
- Sub-module `bin2bcd_seq`:
  - Interface: `start`, 32-bit input, `done` pulse, 8×4 BCD output.
  - Implements 32 iterations of add-3-then-shift, one per cycle.
  - Shares `clk`/`reset`.

## Test plan
- Reset then client 2 requests hex 32'h1234_ABCD, `dp` 8'h01 -> `ack[2]` in T+1; `encoded` = {1,2,3,4,A,B,C,D} (MSB first), `digit_point` = 8'h01 in T+1; `busy` for exactly `HOLD_CYCLES`.
- Client 0 decimal 32'd12345678 -> `encoded` = {1,2,3,4,5,6,7,8} appears in T+33; `encoded` unchanged during T+1..T+32.
- Decimal 32'd100_000_000 -> all digits 4'hE, `digit_point` 0 in T+1; no CONVERT cycles.
- All 4 clients request continuously from reset -> grant order 0,1,2,3,0; each `ack` a single pulse; grants spaced by `HOLD_CYCLES`+1 (hex).
- Reset asserted at cycle T+10 of a decimal conversion -> next cycle IDLE, `encoded` = 0, no `ack`; the following grant goes to client 0 if requesting.
- Client 1 drops `req` while client 3 holds the display -> after HOLD only the remaining requesters are granted; client 1 never receives `ack`.

Source files
------------

// File: rtl/seven_segment_ctrl_pkg.sv
// Shared types and constants for the seven-segment display scheduler and its
// BCD conversion engine.
package seven_segment_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    HOLD
  } ctrl_state_t;

  localparam int          NUM_DIGITS = 8;
  localparam logic [31:0] DEC_MAX    = 32'd99_999_999;
  localparam logic [3:0]  OVF_CODE   = 4'hE;

  // Frame shown when a decimal value cannot fit in eight digits.
  function automatic logic [NUM_DIGITS-1:0][3:0] ovf_frame();
    logic [NUM_DIGITS-1:0][3:0] f;
    for (int d = 0; d < NUM_DIGITS; d++) f[d] = OVF_CODE;
    return f;
  endfunction

endpackage

// File: rtl/seven_segment_ctrl_if.sv
// Client-side request bus of the display scheduler: level requests, per-client
// payloads, and the one-cycle ack returned to the granted client.
interface seven_segment_ctrl_if #(
  parameter int NUM_CLIENTS = 4
);
  logic [NUM_CLIENTS-1:0]       req;
  logic [NUM_CLIENTS-1:0][31:0] value;
  logic [NUM_CLIENTS-1:0]       dec_mode;
  logic [NUM_CLIENTS-1:0][7:0]  dp;
  logic [NUM_CLIENTS-1:0]       ack;

  modport master (output req, value, dec_mode, dp, input ack);
  modport slave  (input req, value, dec_mode, dp, output ack);
endinterface

// File: rtl/seven_segment_ctrl_bin2bcd.sv
// Sequential double-dabble: 32 add-3-then-shift iterations, one per clock.
// The start edge performs the first iteration; done pulses when all 32 are in.
module bin2bcd_seq
  import seven_segment_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [31:0]                bin,
  output logic                       done,
  output logic [NUM_DIGITS-1:0][3:0] bcd
);

  logic [31:0] bcd_sr;
  logic [31:0] bin_sr;
  logic [5:0]  cnt;

  function automatic logic [63:0] dabble_step(input logic [31:0] b, input logic [31:0] s);
    logic [31:0] adj;
    adj = b;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    return {adj, s} << 1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      bcd_sr <= '0;
      bin_sr <= '0;
    end else if (start) begin
      cnt              <= 6'd1;
      {bcd_sr, bin_sr} <= dabble_step(32'd0, bin);
    end else if (cnt == 6'd32) begin
      cnt <= '0;
    end else if (cnt != 6'd0) begin
      cnt              <= cnt + 6'd1;
      {bcd_sr, bin_sr} <= dabble_step(bcd_sr, bin_sr);
    end
  end

  assign done = (cnt == 6'd32);
  assign bcd  = bcd_sr;

endmodule

// File: rtl/seven_segment_ctrl.sv
// Round-robin scheduler sharing one 8-digit seven-segment display among
// several clients; hex frames load immediately, decimal frames go through BCD.
module seven_segment_ctrl
  import seven_segment_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int HOLD_CYCLES = 100000
) (
  input  logic                           clk,
  input  logic                           reset,
  seven_segment_ctrl_if.slave            bus,
  output logic [NUM_DIGITS-1:0][3:0]     encoded,
  output logic [7:0]                     digit_point,
  output logic                           busy,
  output logic [$clog2(NUM_CLIENTS)-1:0] owner
);

  localparam int OW = $clog2(NUM_CLIENTS);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  ctrl_state_t                state, state_n;
  logic [HW-1:0]              hold_cnt;
  logic [NUM_CLIENTS-1:0]     ack_r;
  logic [7:0]                 dp_cap;
  logic                       grant_hit;
  logic [OW-1:0]              grant_idx;
  logic [31:0]                sel_value;
  logic                       sel_dec;
  logic [7:0]                 sel_dp;
  logic                       sel_ovf;
  logic                       grant;
  logic                       conv_start;
  logic                       hold_done;
  logic                       conv_done;
  logic [NUM_DIGITS-1:0][3:0] conv_bcd;

  function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int offs);
    return OW'((int'(base) + offs) % NUM_CLIENTS);
  endfunction

  // Walk the search order backwards so the nearest requester after owner wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = owner;
    for (int i = NUM_CLIENTS; i >= 1; i--) begin
      if (bus.req[rr_idx(owner, i)]) begin
        grant_hit = 1'b1;
        grant_idx = rr_idx(owner, i);
      end
    end
  end

  assign sel_value = bus.value[grant_idx];
  assign sel_dec   = bus.dec_mode[grant_idx];
  assign sel_dp    = bus.dp[grant_idx];
  assign sel_ovf   = sel_dec && (sel_value > DEC_MAX);
  assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));

  always_comb begin
    state_n    = state;
    grant      = 1'b0;
    conv_start = 1'b0;
    case (state)
      IDLE: begin
        if (grant_hit) begin
          grant = 1'b1;
          if (sel_dec && !sel_ovf) begin
            conv_start = 1'b1;
            state_n    = CONVERT;
          end else begin
            state_n = HOLD;
          end
        end
      end
      CONVERT: if (conv_done) state_n = HOLD;
      HOLD:    if (hold_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OW'(NUM_CLIENTS - 1);
      ack_r       <= '0;
      encoded     <= '0;
      digit_point <= '0;
      hold_cnt    <= '0;
    end else begin
      state <= state_n;
      ack_r <= '0;
      if (grant) begin
        owner            <= grant_idx;
        ack_r[grant_idx] <= 1'b1;
        if (!sel_dec) begin
          encoded     <= sel_value;
          digit_point <= sel_dp;
        end else if (sel_ovf) begin
          encoded     <= ovf_frame();
          digit_point <= 8'h00;
        end
      end
      if (state == CONVERT && conv_done) begin
        encoded     <= conv_bcd;
        digit_point <= dp_cap;
      end
      if (state == HOLD && !hold_done) hold_cnt <= hold_cnt + HW'(1);
      else                             hold_cnt <= '0;
    end
  end

  // Digit points of a decimal frame are applied only once its digits land.
  always_ff @(posedge clk) begin
    if (grant) dp_cap <= sel_dp;
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (sel_value),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign bus.ack = ack_r;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_seven_segment_ctrl.sv
// Directed bench for seven_segment_ctrl: a vector table of single-client frames
// followed by hand-written round-robin, reset-abort and withdrawal sequences.
module tb_seven_segment_ctrl;
  localparam int NC = 4;
  localparam int H  = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0][3:0]  encoded;
  logic [7:0]       digit_point;
  logic             busy;
  logic [1:0]       owner;

  int n_cmp = 0;
  int n_bad = 0;

  seven_segment_ctrl_if #(.NUM_CLIENTS(NC)) bus ();

  seven_segment_ctrl #(.NUM_CLIENTS(NC), .HOLD_CYCLES(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .encoded     (encoded),
    .digit_point (digit_point),
    .busy        (busy),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          client;
    logic [31:0] value;
    logic        dec;
    logic [7:0]  dp;
    logic [31:0] exp_enc;
    logic [7:0]  exp_dp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 300) begin
      tick();
      guard++;
    end
    check("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] prev;
    int          cyc, busy_cnt, load_cyc;
    bit          is_conv, enc_ok, ack_extra;
    prev    = encoded;
    is_conv = v.dec && (v.value <= 32'd99_999_999);
    load_cyc = is_conv ? 33 : 1;
    bus.req[v.client]      = 1'b1;
    bus.value[v.client]    = v.value;
    bus.dec_mode[v.client] = v.dec;
    bus.dp[v.client]       = v.dp;
    tick();
    check($sformatf("v%0d_ack", idx), bus.ack, 64'(4'b0001 << v.client));
    check($sformatf("v%0d_owner", idx), owner, 64'(v.client));
    bus.req[v.client] = 1'b0;
    cyc = 1; busy_cnt = 0; enc_ok = 1'b1; ack_extra = 1'b0;
    while (busy && cyc < 200) begin
      busy_cnt++;
      if (cyc < load_cyc) begin
        if (encoded !== prev) enc_ok = 1'b0;
      end else if (cyc == load_cyc) begin
        check($sformatf("v%0d_enc", idx), encoded, v.exp_enc);
        check($sformatf("v%0d_dp", idx), digit_point, v.exp_dp);
      end else if (encoded !== v.exp_enc) begin
        enc_ok = 1'b0;
      end
      if (cyc > 1 && bus.ack != '0) ack_extra = 1'b1;
      tick();
      cyc++;
    end
    check($sformatf("v%0d_busy_len", idx), busy_cnt, is_conv ? 32 + H : H);
    check($sformatf("v%0d_enc_stable", idx), enc_ok, 1);
    check($sformatf("v%0d_no_extra_ack", idx), ack_extra, 0);
    check($sformatf("v%0d_retain", idx), encoded, v.exp_enc);
  endtask

  initial begin
    int  ack_cyc[$];
    int  ack_who[$];
    bit  onehot_ok, consec_ok, last_ack;
    int  c1_acks, c0_acks;
    vec_t tmp;

    bus.req = '0; bus.value = '0; bus.dec_mode = '0; bus.dp = '0;

    vecs[0] = '{2, 32'h1234_ABCD, 1'b0, 8'h01, 32'h1234_ABCD, 8'h01};
    vecs[1] = '{0, 32'd12345678,  1'b1, 8'h80, 32'h1234_5678, 8'h80};
    vecs[2] = '{1, 32'd100000000, 1'b1, 8'hFF, 32'hEEEE_EEEE, 8'h00};
    vecs[3] = '{3, 32'd99999999,  1'b1, 8'h0F, 32'h9999_9999, 8'h0F};
    vecs[4] = '{0, 32'd0,         1'b1, 8'h00, 32'h0000_0000, 8'h00};
    vecs[5] = '{2, 32'hFFFF_FFFF, 1'b0, 8'hAA, 32'hFFFF_FFFF, 8'hAA};
    vecs[6] = '{1, 32'hFFFF_FFFF, 1'b1, 8'h3C, 32'hEEEE_EEEE, 8'h00};
    vecs[7] = '{3, 32'd90817263,  1'b1, 8'h12, 32'h9081_7263, 8'h12};

    tick(); tick();
    reset = 1'b0;
    check("rst_encoded", encoded, 0);
    check("rst_dp", digit_point, 0);
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_owner", owner, NC - 1);
    check("rst_ack", bus.ack, 0);
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
      wait_idle();
    end

    // All clients request continuously from reset: hex round robin.
    reset = 1'b1;
    for (int c = 0; c < NC; c++) begin
      bus.value[c] = 32'hA000_0000 + 32'(c);
      bus.dec_mode[c] = 1'b0;
      bus.dp[c] = 8'(c);
    end
    tick();
    reset = 1'b0;
    bus.req = 4'hF;
    onehot_ok = 1'b1; consec_ok = 1'b1; last_ack = 1'b0;
    for (int cyc = 1; cyc <= 5 * (H + 1); cyc++) begin
      tick();
      if (bus.ack != '0) begin
        if (!$onehot(bus.ack)) onehot_ok = 1'b0;
        if (last_ack) consec_ok = 1'b0;
        ack_cyc.push_back(cyc);
        for (int c = 0; c < NC; c++) if (bus.ack[c]) ack_who.push_back(c);
      end
      last_ack = (bus.ack != '0);
    end
    bus.req = '0;
    check("rr_ack_count", ack_cyc.size(), 5);
    check("rr_onehot", onehot_ok, 1);
    check("rr_not_consecutive", consec_ok, 1);
    for (int k = 0; k < 5 && k < ack_cyc.size() && k < ack_who.size(); k++) begin
      check($sformatf("rr_order%0d", k), ack_who[k], k % NC);
      check($sformatf("rr_cycle%0d", k), ack_cyc[k], 1 + k * (H + 1));
    end
    wait_idle();

    // Reset in the middle of a decimal conversion.
    bus.req[1] = 1'b1; bus.value[1] = 32'd12345678; bus.dec_mode[1] = 1'b1;
    tick();
    check("rstmid_ack", bus.ack, 4'b0010);
    bus.req[1] = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", {63'd0, busy}, 0);
    check("rstmid_encoded", encoded, 0);
    check("rstmid_ack_none", bus.ack, 0);
    check("rstmid_owner", owner, NC - 1);
    bus.req[0] = 1'b1; bus.req[1] = 1'b1; bus.dec_mode[0] = 1'b0;
    tick();
    check("rstmid_next_grant", bus.ack, 4'b0001);
    bus.req = '0;
    wait_idle();

    // Client 1 withdraws while client 3 holds the display.
    tmp = '{2, 32'h0000_2222, 1'b0, 8'h00, 32'h0000_2222, 8'h00};
    run_vec(tmp, 8);
    wait_idle();
    bus.req = 4'b1011;
    tick();
    check("wd_first_grant", bus.ack, 4'b1000);
    bus.req[3] = 1'b0;
    tick(); tick();
    bus.req[1] = 1'b0;
    c1_acks = 0; c0_acks = 0;
    for (int k = 0; k < 3 * (H + 1); k++) begin
      tick();
      if (bus.ack[1]) c1_acks++;
      if (bus.ack[0]) begin
        c0_acks++;
        bus.req[0] = 1'b0;
      end
    end
    check("wd_client1_acks", c1_acks, 0);
    check("wd_client0_acks", c0_acks, 1);
    check("wd_owner", owner, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
